// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if: hazard inputs from the stage modules and latch controls back to them.
interface pipeline_sequencer_if #(
    parameter int CNT_W  = 32,
    parameter int FCNT_W = 16
);
    logic [4:0]        id_rs, id_rt, ex_wsel;
    logic              id_uses_rt, ex_memRead, ex_branch_taken;
    logic              mem_dREN, mem_dWEN, dhit, ihit, wb_halt;
    logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic              ifid_flush, idex_flush, halted;
    logic [CNT_W-1:0]  stall_cnt;
    logic [FCNT_W-1:0] flush_cnt;

    modport master (
        input  id_rs, id_rt, id_uses_rt, ex_memRead, ex_wsel, ex_branch_taken,
               mem_dREN, mem_dWEN, dhit, ihit, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
    );
    modport slave (
        output id_rs, id_rt, id_uses_rt, ex_memRead, ex_wsel, ex_branch_taken,
               mem_dREN, mem_dWEN, dhit, ihit, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: hazard/stall controller driving the PC enable and pipeline latch enables/flushes,
// with saturating stall and branch-flush counters.
module pipeline_sequencer #(
    parameter int CNT_W  = 32,
    parameter int FCNT_W = 16
) (
    input logic CLK,
    input logic nRST,
    pipeline_sequencer_if.master bus
);
    typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [FCNT_W-1:0] flush_q, flush_d;
    logic              dreq, lu_hazard;
    logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;

    assign dreq      = bus.mem_dREN | bus.mem_dWEN;
    assign lu_hazard = bus.ex_memRead & (bus.ex_wsel != 5'd0) &
                       ((bus.ex_wsel == bus.id_rs) | (bus.id_uses_rt & (bus.ex_wsel == bus.id_rt)));

    // DWAIT shares the RUN rules once dhit arrives, so a held branch or hazard resolves that same cycle.
    always_comb begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} = 7'b0000000;
        state_d = state_q;
        flush_d = flush_q;
        if (!nRST) begin
            {ifid_flush, idex_flush} = 2'b11;
            state_d = RUN;
        end else if (state_q == HALTED || bus.wb_halt) begin
            state_d = HALTED;
        end else if (dreq && !bus.dhit) begin
            state_d = DWAIT;
        end else begin
            state_d = RUN;
            if (bus.ex_branch_taken) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} = 7'b1111111;
                flush_d = (&flush_q) ? flush_q : flush_q + 1'b1;
            end else if (lu_hazard) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} = 7'b0001101;
            end else if (!bus.ihit) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} = 7'b0011110;
            end else begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} = 7'b1111100;
            end
        end
        stall_d = (!pc_en && state_q != HALTED && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.pc_en      = pc_en;
    assign bus.ifid_en    = ifid_en;
    assign bus.idex_en    = idex_en;
    assign bus.exmem_en   = exmem_en;
    assign bus.memwb_en   = memwb_en;
    assign bus.ifid_flush = ifid_flush;
    assign bus.idex_flush = idex_flush;
    assign bus.halted     = (state_q == HALTED);
    assign bus.stall_cnt  = stall_q;
    assign bus.flush_cnt  = flush_q;
endmodule
